// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
// 2D address generator. On start (sampled only in IDLE) the configuration is
// latched and the block emits base + j*y_stride + i*x_stride for every element
// of an x_count by y_count window in row-major order, one address per
// accepted handshake. Addresses are built incrementally from a row-start
// register, so only adders are used. A one-cycle done pulse marks the end of
// every scan, whether it ran to completion or was aborted.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   start       request a new scan (IDLE only)
//   abort       terminate a running scan (RUN only)
//   base        address of element (0,0)
//   x_stride    inner-loop stride, zero-extended to 32 bits
//   x_count     elements per row
//   y_stride    row stride
//   y_count     number of rows
//   addr        current scan address
//   addr_valid  addr is valid
//   addr_ready  consumer accepts addr
//   busy        high whenever the FSM is not IDLE
//   done        one-cycle pulse at scan end
// -----------------------------------------------------------------------------
module scan_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      base,
  input  logic [11:0]      x_stride,
  input  logic [CNT_W-1:0] x_count,
  input  logic [31:0]      y_stride,
  input  logic [CNT_W-1:0] y_count,
  output logic [31:0]      addr,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [31:0]      r_addr;
  logic [31:0]      r_row_start;
  logic [CNT_W-1:0] r_i;
  logic [CNT_W-1:0] r_j;
  logic [11:0]      r_x_stride;
  logic [CNT_W-1:0] r_x_count;
  logic [31:0]      r_y_stride;
  logic [CNT_W-1:0] r_y_count;

  logic             w_accept;
  logic             w_empty;
  logic             w_xfer;
  logic             w_last_i;
  logic             w_last_j;
  logic             w_last_elem;
  logic [31:0]      w_next_row;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_empty     = (x_count == '0) || (y_count == '0);
  // addr_valid is exactly "state is RUN", so a transfer needs only ready.
  assign w_xfer      = (r_state == S_RUN) && addr_ready;
  assign w_last_i    = (r_i == (r_x_count - ONE));
  assign w_last_j    = (r_j == (r_y_count - ONE));
  assign w_last_elem = w_last_i && w_last_j;
  assign w_next_row  = r_row_start + r_y_stride;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_empty ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort || (w_xfer && w_last_elem)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    addr_valid = (r_state == S_RUN);
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
  end

  assign addr = r_addr;

  // Config latch, loop counters and incremental address generation.
  // After the final element the counters and address simply hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_row_start <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_x_stride  <= '0;
      r_x_count   <= '0;
      r_y_stride  <= '0;
      r_y_count   <= '0;
    end else if (w_accept) begin
      r_addr      <= base;
      r_row_start <= base;
      r_i         <= '0;
      r_j         <= '0;
      r_x_stride  <= x_stride;
      r_x_count   <= x_count;
      r_y_stride  <= y_stride;
      r_y_count   <= y_count;
    end else if (w_xfer && !w_last_elem) begin
      if (w_last_i) begin
        r_i         <= '0;
        r_j         <= r_j + ONE;
        r_row_start <= w_next_row;
        r_addr      <= w_next_row;
      end else begin
        r_i    <= r_i + ONE;
        r_addr <= r_addr + {20'd0, r_x_stride};
      end
    end
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of x_count/y_count and the internal loop counters.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request a new 2D scan; sampled only in IDLE.
REQ-006 abort  input  1  terminate the running scan early.
REQ-007 base  input  32  address of element (0,0).
REQ-008 x_stride  input  12  inner-loop stride, zero-extended to 32 bits.
REQ-009 x_count  input  CNT_W  elements per row.
REQ-010 y_stride  input  32  outer-loop (row) stride.
REQ-011 y_count  input  CNT_W  number of rows.
REQ-012 addr  output  32  current scan address.
REQ-013 addr_valid  output  1  addr is valid.
REQ-014 addr_ready  input  1  consumer accepts addr.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 done  output  1  one-cycle pulse at scan end (normal or aborted).

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-018 In IDLE with start=1, the block SHALL latch base, x_stride, x_count, y_stride, y_count; config inputs are ignored at all other times.
REQ-019 On an accepted start with x_count!=0 and y_count!=0, the next cycle SHALL be RUN with addr=base, addr_valid=1 (latency one cycle).
REQ-020 On an accepted start with x_count==0 or y_count==0, the next cycle SHALL be DONE with addr_valid never asserted.
REQ-021 The address for element (i,j) SHALL be base + j*y_stride + i*x_stride modulo 2^32, i inner (0..x_count-1), j outer (0..y_count-1), row-major order.
REQ-022 Addresses SHALL be generated incrementally with a row-start register and adders only; no multipliers.
REQ-023 A transfer SHALL occur on a cycle with addr_valid=1 and addr_ready=1; the next address appears the following cycle, giving one address per cycle under continuous ready.
REQ-024 While addr_valid=1 and addr_ready=0, addr and addr_valid SHALL hold stable.
REQ-025 At a transfer with i=x_count-1 and j<y_count-1, i SHALL reset to 0, j increment, and addr become row_start+y_stride.
REQ-026 At the transfer of element (x_count-1, y_count-1), the next state SHALL be DONE.
REQ-027 In DONE, done=1, addr_valid=0, busy=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-028 abort=1 in RUN SHALL move to DONE next cycle; a transfer in that same cycle counts as completed; abort SHALL be ignored in IDLE and DONE.
REQ-029 start SHALL be ignored in RUN and DONE; a start in the IDLE cycle immediately following DONE SHALL be accepted.
REQ-030 Address arithmetic SHALL wrap modulo 2^32 without any flag; counter comparisons SHALL use CNT_W bits.
REQ-031 addr SHALL hold its last value when addr_valid=0; consumers must not rely on it.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, addr=0, addr_valid=0, busy=0, done=0 and clear counters and latched config, regardless of clock.
REQ-033 Reset mid-scan SHALL discard the scan; the first start after rst deassertion SHALL behave as a fresh scan.
REQ-034 Reset deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-035 base=0x100, x_stride=4, x_count=3, y_stride=0x40, y_count=2, addr_ready=1 -> addr 0x100,0x104,0x108,0x140,0x144,0x148 on six consecutive cycles starting one cycle after start; done pulse the cycle after 0x148; busy low the cycle after done.
REQ-036 Same config, addr_ready pattern 1,0,0,1,0,1,1,1... -> identical address sequence; addr held stable during every ready=0 cycle; exactly six transfers.
REQ-037 x_count=0, y_count=5, start at cycle N -> addr_valid never high; done=1 at N+1; busy=0 at N+2.
REQ-038 base=0xFFFF_FFFC, x_stride=8, x_count=2, y_count=1 -> addr 0xFFFF_FFFC then 0x0000_0004; done follows.
REQ-039 Config of REQ-035, abort asserted together with the second transfer -> 0x100,0x104 transferred, addr_valid=0 next cycle with done=1; a new start then reproduces REQ-035 exactly; start pulses during RUN ignored.
REQ-040 rst asserted mid-scan between clock edges -> all outputs 0 before the next edge; after release, no activity until start.
